vector_collector: RTL
=====================

# vector_collector

Collects the element-serial output stream of a generator layer into one flat, packed vector for the combinational `vector_expander` ahead of the discriminator. Each accepted sample is rescaled from accumulator precision to the `DATA_WIDTH` fixed-point format and saturated. The completed vector is held stable under a valid/ack handshake until the consumer takes it. Framing is checked against an end-of-frame marker.

## Interface
- `ELEMENT_COUNT`, 128, elements per vector (≥2)
- `DATA_WIDTH`, 16, signed output element width
- `IN_WIDTH`, 32, signed input sample width (> `DATA_WIDTH`)
- `FRAC_SHIFT`, 8, arithmetic right shift applied to each input sample (0 ≤ `FRAC_SHIFT` < `IN_WIDTH`)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `clear` in 1: abort the current frame and release any held vector
- `in_valid` in 1: input sample valid
- `in_ready` out 1: collector can accept a sample (registered)
- `in_data` in `IN_WIDTH`: signed input sample
- `in_last` in 1: marks the final sample of a frame
- `vector_out` out `DATA_WIDTH*ELEMENT_COUNT`: packed vector; element k at `[(k+1)*DATA_WIDTH-1 -: DATA_WIDTH]`
- `vector_valid` out 1: `vector_out` is complete and stable
- `vector_ack` in 1: consumer takes the vector
- `busy` out 1: partial frame in progress
- `done` out 1: one-cycle pulse when a vector completes
- `frame_error` out 1: sticky framing error

## Operation
- FSM states:
  - COLLECT: `idx` runs 0..`ELEMENT_COUNT`-1.
  - HOLD: `vector_valid`=1.
- Accept = `in_valid && in_ready`. The accepted sample is converted and written to element `idx`, then `idx` increments. The first sample of a frame lands in element 0.
- Conversion: arithmetic shift right by `FRAC_SHIFT` (floor), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Accept at `idx`=`ELEMENT_COUNT`-1 → go to HOLD, pulse `done`, `idx`←0.
  - If `in_last`=0 on this sample, set `frame_error`; the vector still completes.
- Accept with `in_last`=1 at `idx` < `ELEMENT_COUNT`-1 → set `frame_error`, discard the partial frame (`idx`←0), stay in COLLECT, no `done`. Already-written elements of `vector_out` keep their stale values.
- HOLD with `vector_ack`=1 → COLLECT. `vector_ack` outside HOLD is ignored.
- `busy` = COLLECT && `idx`≠0.
- Priority: `rst` > `clear` > normal operation.
  - `clear`: state←COLLECT, `idx`←0, `vector_valid`←0, `frame_error`←0. `vector_out` is not cleared.
  - A sample presented in the same cycle as `clear` is dropped.
- `vector_out` changes only on accepts, i.e. never while `vector_valid`=1.

## Timing
- Reset values:
  - `in_ready`=0, `vector_valid`=0, `done`=0, `busy`=0, `frame_error`=0.
  - `vector_out`=0, state=COLLECT, `idx`=0.
- `in_ready` rises the first cycle after `rst` deasserts.
- Throughput: one sample per cycle while in COLLECT.
- Last sample accepted at edge t:
  - `vector_valid`=1 and `done`=1 from t+1.
  - `in_ready`=0 from t+1.
  - `done` is low again at t+2.
- `vector_ack` sampled high at edge t: `vector_valid`=0 and `in_ready`=1 from t+1.
  - Minimum gap between frames is one cycle.
- No combinational path from `vector_ack` or `in_valid` to any output.
- `clear` at edge t: all effects visible at t+1.

## Structure
- Shared package `ganmind_fixed_pkg` holds:
  - `clog2` function for sizing `idx` (minimum 1 bit).
  - `sat_shift` function: shift plus saturation, parameterised by `IN_WIDTH`, `DATA_WIDTH`, `FRAC_SHIFT`.
- Natural sub-module: `fixed_point_saturator`, combinational, `IN_WIDTH` → `DATA_WIDTH`.
- The FSM and packing logic stay in `vector_collector`.

## Test plan
All scenarios use `ELEMENT_COUNT`=4, `DATA_WIDTH`=16, `IN_WIDTH`=32, `FRAC_SHIFT`=8.
- **Nominal frame:** send 0x00000100, 0x00000200, 0xFFFFFF00, 0x00000000 back-to-back, `in_last` on the 4th sample. Expect `vector_out`=0x0000_FFFF_0002_0001 one cycle after the 4th accept, a single `done` pulse, and `frame_error`=0.
- **Saturation:** send 0x00FFFF00, 0x80000000, 0xFFFFFFFF, 0x00007FFF. Expect elements 0x7FFF, 0x8000, 0xFFFF, 0x007F.
- **Backpressure:** hold `vector_ack`=0 for 10 cycles after `done` while `in_valid` stays high. Expect `in_ready`=0 and `vector_out` stable throughout. Ack → `in_ready`=1 on the next cycle and the next frame starts at element 0.
- **Early last:** assert `in_last` on the 2nd sample. Expect `frame_error`=1, no `done`. The following 4-sample frame completes normally with `frame_error` still 1.
- **Missing last:** send 4 samples with `in_last`=0 throughout. Expect `done`, `vector_valid`, and `frame_error`=1.
- **Clear and reset mid-frame:** after 2 accepts, pulse `clear` while `in_valid`=1. Expect `busy`=0 next cycle, the sample in the `clear` cycle dropped, and the next frame's first sample landing in element 0. Repeat with `rst`: expect every output at its reset value and `in_ready` high one cycle after `rst` deasserts.

Source files
------------

// File: rtl/ganmind_fixed_pkg.sv
// Shared fixed-point helpers: index sizing and rescale-with-saturation of wide samples.
package ganmind_fixed_pkg;

   localparam int unsigned SAT_MAX_W = 64;

   // Bits needed to index 'value' entries, never less than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Floor shift right by frac_shift, then clamp to the signed data_width range.
   function automatic logic signed [SAT_MAX_W-1:0] sat_shift(
      input logic signed [SAT_MAX_W-1:0] x,
      input int unsigned                 data_width,
      input int unsigned                 frac_shift
   );
      logic signed [SAT_MAX_W-1:0] shifted;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      shifted = x >>> frac_shift;
      hi      = (64'sd1 <<< (data_width - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      if (shifted > hi)      return hi;
      else if (shifted < lo) return lo;
      else                   return shifted;
   endfunction

endpackage

// File: rtl/fixed_point_saturator.sv
// Combinational rescale of one accumulator-precision sample to the output fixed-point format.
module fixed_point_saturator
   import ganmind_fixed_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_SHIFT = 8
) (
   input  logic signed [IN_WIDTH-1:0]   in_data,
   output logic signed [DATA_WIDTH-1:0] out_data_c
);

   logic signed [SAT_MAX_W-1:0] wide_c;

   assign wide_c     = SAT_MAX_W'(in_data);
   assign out_data_c = DATA_WIDTH'(sat_shift(wide_c, DATA_WIDTH, FRAC_SHIFT));

endmodule

// File: rtl/vector_collector.sv
// Packs an element-serial sample stream into one flat vector, held under valid/ack until taken.
module vector_collector
   import ganmind_fixed_pkg::*;
#(
   parameter int unsigned ELEMENT_COUNT = 128,
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned IN_WIDTH      = 32,
   parameter int unsigned FRAC_SHIFT    = 8
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic signed [IN_WIDTH-1:0]          in_data,
   input  logic                                in_last,
   output logic [DATA_WIDTH*ELEMENT_COUNT-1:0] vector_out,
   output logic                                vector_valid,
   input  logic                                vector_ack,
   output logic                                busy,
   output logic                                done,
   output logic                                frame_error
);

   localparam int unsigned IDX_W = clog2(ELEMENT_COUNT);
   localparam int unsigned VEC_W = DATA_WIDTH * ELEMENT_COUNT;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMENT_COUNT - 1);

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   vec_q;
   logic               in_ready_q, in_ready_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               wr_en_c;
   logic               accept_c;
   logic [DATA_WIDTH-1:0] sample_c;

   fixed_point_saturator #(
      .IN_WIDTH   (IN_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_sat (
      .in_data    (in_data),
      .out_data_c (sample_c)
   );

   assign accept_c = in_valid && in_ready_q;

   // Next-state and registered-output decode; clear outranks all normal activity.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      err_d       = err_q;
      done_d      = 1'b0;
      wr_en_c     = 1'b0;
      if (clear) begin
         state_d = ST_COLLECT;
         idx_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (accept_c) begin
                  wr_en_c = 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state_d = ST_HOLD;
                     done_d  = 1'b1;
                     idx_d   = '0;
                     if (!in_last) err_d = 1'b1;
                  end else if (in_last) begin
                     err_d = 1'b1;
                     idx_d = '0;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (vector_ack) state_d = ST_COLLECT;
            end
            default: state_d = ST_COLLECT;
         endcase
      end
      in_ready_d = (state_d == ST_COLLECT);
      valid_d    = (state_d == ST_HOLD);
      busy_d     = (state_d == ST_COLLECT) && (idx_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_COLLECT;
         idx_q      <= '0;
         in_ready_q <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         in_ready_q <= in_ready_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Element write at the current index; stale elements survive aborts and clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q <= '0;
      end else if (wr_en_c) begin
         for (int unsigned k = 0; k < ELEMENT_COUNT; k++) begin
            if (idx_q == IDX_W'(k)) vec_q[k*DATA_WIDTH +: DATA_WIDTH] <= sample_c;
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign vector_out   = vec_q;
   assign vector_valid = valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign frame_error  = err_q;

endmodule
